// File: rtl/twd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : twd_cmd_arbiter
// Description : Round-robin arbiter sharing one 2D transfer splitter between
//               NB_REQ command sources. The winning source's full 2D command
//               is captured in a register and offered to the splitter with a
//               req/gnt handshake. Fields pass through bit-exact.
// Revision    : 1.0 - initial release
// ============================================================================
module twd_cmd_arbiter #(
    parameter int NB_REQ           = 2,
    parameter int TRANS_SID_WIDTH  = 1,
    parameter int TCDM_ADD_WIDTH   = 12,
    parameter int EXT_ADD_WIDTH    = 29,
    parameter int TWD_COUNT_WIDTH  = 16,
    parameter int TWD_STRIDE_WIDTH = 16,
    parameter int MCHAN_OPC_WIDTH  = 4,
    parameter int MCHAN_LEN_WIDTH  = 17,
    localparam int SEL_WIDTH       = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,

    // per-source request side
    input  logic [NB_REQ-1:0]                             req_i,
    output logic [NB_REQ-1:0]                             gnt_o,
    input  logic [NB_REQ-1:0][TRANS_SID_WIDTH-1:0]        sid_i,
    input  logic [NB_REQ-1:0][MCHAN_OPC_WIDTH-1:0]        opc_i,
    input  logic [NB_REQ-1:0][MCHAN_LEN_WIDTH-1:0]        len_i,
    input  logic [NB_REQ-1:0]                             inc_i,
    input  logic [NB_REQ-1:0]                             twd_ext_i,
    input  logic [NB_REQ-1:0]                             twd_tcdm_i,
    input  logic [NB_REQ-1:0][TWD_COUNT_WIDTH-1:0]        ext_count_i,
    input  logic [NB_REQ-1:0][TWD_STRIDE_WIDTH-1:0]       ext_stride_i,
    input  logic [NB_REQ-1:0][TWD_COUNT_WIDTH-1:0]        tcdm_count_i,
    input  logic [NB_REQ-1:0][TWD_STRIDE_WIDTH-1:0]       tcdm_stride_i,
    input  logic [NB_REQ-1:0][TCDM_ADD_WIDTH-1:0]         tcdm_add_i,
    input  logic [NB_REQ-1:0][EXT_ADD_WIDTH-1:0]          ext_add_i,

    // splitter command side
    output logic                                          mchan_req_o,
    input  logic                                          mchan_gnt_i,
    output logic [TRANS_SID_WIDTH-1:0]                    mchan_sid_o,
    output logic [MCHAN_OPC_WIDTH-1:0]                    mchan_opc_o,
    output logic [MCHAN_LEN_WIDTH-1:0]                    mchan_len_o,
    output logic                                          mchan_inc_o,
    output logic                                          mchan_twd_ext_o,
    output logic                                          mchan_twd_tcdm_o,
    output logic [TWD_COUNT_WIDTH-1:0]                    mchan_ext_count_o,
    output logic [TWD_STRIDE_WIDTH-1:0]                   mchan_ext_stride_o,
    output logic [TWD_COUNT_WIDTH-1:0]                    mchan_tcdm_count_o,
    output logic [TWD_STRIDE_WIDTH-1:0]                   mchan_tcdm_stride_o,
    output logic [TCDM_ADD_WIDTH-1:0]                     mchan_tcdm_add_o,
    output logic [EXT_ADD_WIDTH-1:0]                      mchan_ext_add_o,

    output logic [SEL_WIDTH-1:0]                          sel_id_o,
    output logic                                          busy_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ARB_IDLE = 1'b0;
    localparam logic [0:0] c_ARB_HOLD = 1'b1;

    localparam logic [SEL_WIDTH:0] c_NB_REQ_EXT = (SEL_WIDTH+1)'(NB_REQ);

    logic [0:0]                  r_state;
    logic [SEL_WIDTH-1:0]        r_rr_ptr;
    logic [SEL_WIDTH-1:0]        r_sel_id;

    logic [TRANS_SID_WIDTH-1:0]  r_sid;
    logic [MCHAN_OPC_WIDTH-1:0]  r_opc;
    logic [MCHAN_LEN_WIDTH-1:0]  r_len;
    logic                        r_inc;
    logic                        r_twd_ext;
    logic                        r_twd_tcdm;
    logic [TWD_COUNT_WIDTH-1:0]  r_ext_count;
    logic [TWD_STRIDE_WIDTH-1:0] r_ext_stride;
    logic [TWD_COUNT_WIDTH-1:0]  r_tcdm_count;
    logic [TWD_STRIDE_WIDTH-1:0] r_tcdm_stride;
    logic [TCDM_ADD_WIDTH-1:0]   r_tcdm_add;
    logic [EXT_ADD_WIDTH-1:0]    r_ext_add;

    logic                        w_any_req;
    logic                        w_grant_now;
    logic                        w_accept;
    logic [SEL_WIDTH-1:0]        w_winner;
    logic [SEL_WIDTH-1:0]        w_next_ptr;
    logic [NB_REQ-1:0]           w_gnt;

    assign w_any_req   = |req_i;
    assign w_grant_now = (r_state == c_ARB_IDLE) && w_any_req;
    assign w_accept    = (r_state == c_ARB_HOLD) && mchan_gnt_i;

    // Winner search: walk the sources starting at the round-robin pointer,
    // wrapping modulo NB_REQ; iterating from the far end down lets the
    // nearest asserted source overwrite any farther one.
    always_comb begin
        logic [SEL_WIDTH:0] v_idx;
        v_idx    = '0;
        w_winner = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            v_idx = {1'b0, r_rr_ptr} + (SEL_WIDTH+1)'(k);
            if (v_idx >= c_NB_REQ_EXT) begin
                v_idx = v_idx - c_NB_REQ_EXT;
            end
            if (req_i[v_idx[SEL_WIDTH-1:0]]) begin
                w_winner = v_idx[SEL_WIDTH-1:0];
            end
        end
    end

    // Pointer moves to the source just after the winner, wrapping modulo NB_REQ.
    always_comb begin
        logic [SEL_WIDTH:0] v_nxt;
        v_nxt = {1'b0, w_winner} + (SEL_WIDTH+1)'(1);
        if (v_nxt >= c_NB_REQ_EXT) begin
            v_nxt = v_nxt - c_NB_REQ_EXT;
        end
        w_next_ptr = v_nxt[SEL_WIDTH-1:0];
    end

    // One-hot grant, only while idle and never during reset.
    always_comb begin
        w_gnt = '0;
        if (w_grant_now && !rst_i) begin
            w_gnt[w_winner] = 1'b1;
        end
    end

    // Arbitration FSM: capture on grant, release on splitter acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_ARB_IDLE;
            r_rr_ptr <= '0;
            r_sel_id <= '0;
        end else begin
            case (r_state)
                c_ARB_IDLE: begin
                    if (w_any_req) begin
                        r_state  <= c_ARB_HOLD;
                        r_sel_id <= w_winner;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                c_ARB_HOLD: begin
                    if (mchan_gnt_i) begin
                        r_state <= c_ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ARB_IDLE;
                end
            endcase
        end
    end

    // Command register: loads the winner's fields on grant and clears on
    // acceptance so the splitter side reads zero whenever nothing is held.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_accept) begin
            r_sid         <= '0;
            r_opc         <= '0;
            r_len         <= '0;
            r_inc         <= 1'b0;
            r_twd_ext     <= 1'b0;
            r_twd_tcdm    <= 1'b0;
            r_ext_count   <= '0;
            r_ext_stride  <= '0;
            r_tcdm_count  <= '0;
            r_tcdm_stride <= '0;
            r_tcdm_add    <= '0;
            r_ext_add     <= '0;
        end else if (w_grant_now) begin
            r_sid         <= sid_i[w_winner];
            r_opc         <= opc_i[w_winner];
            r_len         <= len_i[w_winner];
            r_inc         <= inc_i[w_winner];
            r_twd_ext     <= twd_ext_i[w_winner];
            r_twd_tcdm    <= twd_tcdm_i[w_winner];
            r_ext_count   <= ext_count_i[w_winner];
            r_ext_stride  <= ext_stride_i[w_winner];
            r_tcdm_count  <= tcdm_count_i[w_winner];
            r_tcdm_stride <= tcdm_stride_i[w_winner];
            r_tcdm_add    <= tcdm_add_i[w_winner];
            r_ext_add     <= ext_add_i[w_winner];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs; handshake flags are forced low while reset is asserted so a
    // held command disappears in the reset cycle itself.
    // ------------------------------------------------------------------------
    assign gnt_o               = w_gnt;
    assign mchan_req_o         = (r_state == c_ARB_HOLD) && !rst_i;
    assign busy_o              = (r_state == c_ARB_HOLD) && !rst_i;
    assign sel_id_o            = r_sel_id;

    assign mchan_sid_o         = r_sid;
    assign mchan_opc_o         = r_opc;
    assign mchan_len_o         = r_len;
    assign mchan_inc_o         = r_inc;
    assign mchan_twd_ext_o     = r_twd_ext;
    assign mchan_twd_tcdm_o    = r_twd_tcdm;
    assign mchan_ext_count_o   = r_ext_count;
    assign mchan_ext_stride_o  = r_ext_stride;
    assign mchan_tcdm_count_o  = r_tcdm_count;
    assign mchan_tcdm_stride_o = r_tcdm_stride;
    assign mchan_tcdm_add_o    = r_tcdm_add;
    assign mchan_ext_add_o     = r_ext_add;

endmodule
`default_nettype wire

// File: tb/tb_twd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_twd_cmd_arbiter
// Description : Self-checking bench for twd_cmd_arbiter. A 2-source instance
//               is compared every cycle against a command-level reference
//               model; a 4-source instance exercises pointer wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twd_cmd_arbiter;

    typedef struct packed {
        logic [0:0]  sid;
        logic [3:0]  opc;
        logic [16:0] len;
        logic        inc;
        logic        twd_ext;
        logic        twd_tcdm;
        logic [15:0] ext_count;
        logic [15:0] ext_stride;
        logic [15:0] tcdm_count;
        logic [15:0] tcdm_stride;
        logic [11:0] tcdm_add;
        logic [28:0] ext_add;
    } cmd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- 2-source instance ----------------
    logic [1:0]        req, gnt;
    logic              mreq, mgnt, busy;
    logic [0:0]        sel;
    logic [1:0][0:0]   sid;
    logic [1:0][3:0]   opc;
    logic [1:0][16:0]  len;
    logic [1:0]        inc, twd_ext, twd_tcdm;
    logic [1:0][15:0]  ext_count, ext_stride, tcdm_count, tcdm_stride;
    logic [1:0][11:0]  tcdm_add;
    logic [1:0][28:0]  ext_add;
    logic [0:0]        o_sid;
    logic [3:0]        o_opc;
    logic [16:0]       o_len;
    logic              o_inc, o_twd_ext, o_twd_tcdm;
    logic [15:0]       o_ext_count, o_ext_stride, o_tcdm_count, o_tcdm_stride;
    logic [11:0]       o_tcdm_add;
    logic [28:0]       o_ext_add;
    cmd_t              src [2];
    cmd_t              obs;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sid[i]         = src[i].sid;
            opc[i]         = src[i].opc;
            len[i]         = src[i].len;
            inc[i]         = src[i].inc;
            twd_ext[i]     = src[i].twd_ext;
            twd_tcdm[i]    = src[i].twd_tcdm;
            ext_count[i]   = src[i].ext_count;
            ext_stride[i]  = src[i].ext_stride;
            tcdm_count[i]  = src[i].tcdm_count;
            tcdm_stride[i] = src[i].tcdm_stride;
            tcdm_add[i]    = src[i].tcdm_add;
            ext_add[i]     = src[i].ext_add;
        end
    end

    assign obs = {o_sid, o_opc, o_len, o_inc, o_twd_ext, o_twd_tcdm, o_ext_count,
                  o_ext_stride, o_tcdm_count, o_tcdm_stride, o_tcdm_add, o_ext_add};

    twd_cmd_arbiter u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(gnt),
        .sid_i(sid), .opc_i(opc), .len_i(len), .inc_i(inc),
        .twd_ext_i(twd_ext), .twd_tcdm_i(twd_tcdm),
        .ext_count_i(ext_count), .ext_stride_i(ext_stride),
        .tcdm_count_i(tcdm_count), .tcdm_stride_i(tcdm_stride),
        .tcdm_add_i(tcdm_add), .ext_add_i(ext_add),
        .mchan_req_o(mreq), .mchan_gnt_i(mgnt),
        .mchan_sid_o(o_sid), .mchan_opc_o(o_opc), .mchan_len_o(o_len),
        .mchan_inc_o(o_inc), .mchan_twd_ext_o(o_twd_ext), .mchan_twd_tcdm_o(o_twd_tcdm),
        .mchan_ext_count_o(o_ext_count), .mchan_ext_stride_o(o_ext_stride),
        .mchan_tcdm_count_o(o_tcdm_count), .mchan_tcdm_stride_o(o_tcdm_stride),
        .mchan_tcdm_add_o(o_tcdm_add), .mchan_ext_add_o(o_ext_add),
        .sel_id_o(sel), .busy_o(busy)
    );

    // ---------------- 4-source instance (wrap-around) ----------------
    logic [3:0]        req4, gnt4;
    logic              mreq4, mgnt4, busy4;
    logic [1:0]        sel4;
    logic [3:0][0:0]   sid4 = '0;
    logic [3:0][3:0]   opc4 = '0;
    logic [3:0][16:0]  len4;
    logic [3:0]        inc4 = '0, twd_ext4 = '0, twd_tcdm4 = '0;
    logic [3:0][15:0]  ext_count4 = '0, ext_stride4 = '0, tcdm_count4 = '0, tcdm_stride4 = '0;
    logic [3:0][11:0]  tcdm_add4 = '0;
    logic [3:0][28:0]  ext_add4 = '0;
    logic [0:0]        o4_sid;
    logic [3:0]        o4_opc;
    logic [16:0]       o4_len;
    logic              o4_inc, o4_twd_ext, o4_twd_tcdm;
    logic [15:0]       o4_ext_count, o4_ext_stride, o4_tcdm_count, o4_tcdm_stride;
    logic [11:0]       o4_tcdm_add;
    logic [28:0]       o4_ext_add;

    twd_cmd_arbiter #(.NB_REQ(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .req_i(req4), .gnt_o(gnt4),
        .sid_i(sid4), .opc_i(opc4), .len_i(len4), .inc_i(inc4),
        .twd_ext_i(twd_ext4), .twd_tcdm_i(twd_tcdm4),
        .ext_count_i(ext_count4), .ext_stride_i(ext_stride4),
        .tcdm_count_i(tcdm_count4), .tcdm_stride_i(tcdm_stride4),
        .tcdm_add_i(tcdm_add4), .ext_add_i(ext_add4),
        .mchan_req_o(mreq4), .mchan_gnt_i(mgnt4),
        .mchan_sid_o(o4_sid), .mchan_opc_o(o4_opc), .mchan_len_o(o4_len),
        .mchan_inc_o(o4_inc), .mchan_twd_ext_o(o4_twd_ext), .mchan_twd_tcdm_o(o4_twd_tcdm),
        .mchan_ext_count_o(o4_ext_count), .mchan_ext_stride_o(o4_ext_stride),
        .mchan_tcdm_count_o(o4_tcdm_count), .mchan_tcdm_stride_o(o4_tcdm_stride),
        .mchan_tcdm_add_o(o4_tcdm_add), .mchan_ext_add_o(o4_ext_add),
        .sel_id_o(sel4), .busy_o(busy4)
    );

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (command level) ----------------
    bit   m_hold = 1'b0;
    int   m_ptr  = 0;
    int   m_sel  = 0;
    int   m_win  = -1;
    cmd_t m_cmd  = '0;

    // First requesting source at or after ptr, circularly; -1 if none.
    function automatic int rr_pick(input logic [3:0] r, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (r[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.sid         = 1'($urandom);
        c.opc         = 4'($urandom);
        c.len         = 17'($urandom);
        c.inc         = 1'($urandom);
        c.twd_ext     = 1'($urandom);
        c.twd_tcdm    = 1'($urandom);
        c.ext_count   = 16'($urandom);
        c.ext_stride  = 16'($urandom);
        c.tcdm_count  = 16'($urandom);
        c.tcdm_stride = 16'($urandom);
        c.tcdm_add    = 12'($urandom);
        c.ext_add     = 29'($urandom);
        return c;
    endfunction

    // Compare the 2-source instance against the model at mid-cycle.
    task automatic sample();
        logic [1:0] eg;
        int w;
        @(negedge clk);
        eg = 2'b00;
        if (!rst && !m_hold) begin
            w = rr_pick({2'b00, req}, m_ptr, 2);
            if (w >= 0) eg = 2'(1 << w);
        end
        chk("gnt", 160'(gnt), 160'(eg));
        chk("mchan_req", 160'(mreq), 160'(!rst && m_hold));
        chk("busy", 160'(busy), 160'(!rst && m_hold));
        if (!rst) begin
            chk("cmd", 160'(obs), m_hold ? 160'(m_cmd) : 160'(0));
            if (m_hold) chk("sel_id", 160'(sel), 160'(m_sel));
        end
    endtask

    // Advance the model at the clock edge, then let stimulus change.
    task automatic tick();
        @(posedge clk);
        m_win = -1;
        if (rst) begin
            m_hold = 1'b0;
            m_ptr  = 0;
            m_cmd  = '0;
        end else if (!m_hold) begin
            m_win = rr_pick({2'b00, req}, m_ptr, 2);
            if (m_win >= 0) begin
                m_hold = 1'b1;
                m_sel  = m_win;
                m_ptr  = (m_win + 1) % 2;
                m_cmd  = src[m_win];
            end
        end else if (mgnt) begin
            m_hold = 1'b0;
            m_cmd  = '0;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cmd_t snap;
        int   fair_win [8];
        int   n_fair;
        logic [1:0] pend;

        rst = 1'b1; req = 2'b11; mgnt = 1'b0;
        src[0] = rnd_cmd(); src[1] = rnd_cmd();
        req4 = '0; mgnt4 = 1'b0;
        for (int i = 0; i < 4; i++) len4[i] = 17'(i);
        #1;

        // reset with both sources requesting
        repeat (2) begin
            sample();
            chk("rst_gnt", 160'(gnt), 160'(0));
            chk("rst_mreq", 160'(mreq), 160'(0));
            chk("rst_busy", 160'(busy), 160'(0));
            tick();
        end
        rst = 1'b0; req = 2'b00;
        cyc();

        // single command from source 0
        src[0] = rnd_cmd();
        src[0].len = 17'h3F; src[0].ext_add = 29'h1000_0000; src[0].twd_ext = 1'b1;
        req = 2'b01;
        sample();
        chk("single_gnt", 160'(gnt), 160'(2'b01));
        tick();
        req = 2'b00; mgnt = 1'b1;
        sample();
        chk("single_mreq", 160'(mreq), 160'(1));
        chk("single_len", 160'(o_len), 160'(17'h3F));
        chk("single_ext_add", 160'(o_ext_add), 160'(29'h1000_0000));
        chk("single_twd_ext", 160'(o_twd_ext), 160'(1));
        chk("single_sel", 160'(sel), 160'(0));
        tick();

        // fairness: both requesting, splitter always ready; pointer is 1 now
        req = 2'b11; mgnt = 1'b1; n_fair = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            if (gnt != 2'b00 && n_fair < 8) begin
                fair_win[n_fair] = (gnt == 2'b10) ? 1 : 0;
                n_fair++;
            end
            tick();
        end
        chk("fair_count", 160'(n_fair), 160'(4));
        for (int i = 0; i < 4 && i < n_fair; i++) begin
            chk("fair_seq", 160'(fair_win[i]), 160'((i + 1) % 2));
        end

        // backpressure: splitter stalls for 5 cycles while source 1 waits
        src[0] = rnd_cmd(); req = 2'b01; mgnt = 1'b0;
        cyc();
        snap = src[0]; req = 2'b10;
        repeat (5) begin
            sample();
            chk("bp_busy", 160'(busy), 160'(1));
            chk("bp_mreq", 160'(mreq), 160'(1));
            chk("bp_gnt", 160'(gnt), 160'(0));
            chk("bp_stable", 160'(obs), 160'(snap));
            tick();
        end
        mgnt = 1'b1;
        cyc();
        sample();
        chk("bp_release_mreq", 160'(mreq), 160'(0));
        chk("bp_next_gnt", 160'(gnt), 160'(2'b10));
        tick();
        req = 2'b00;
        cyc();

        // reset while holding a command
        src[0] = rnd_cmd(); req = 2'b01; mgnt = 1'b0;
        cyc();
        req = 2'b00; rst = 1'b1;
        cyc();
        rst = 1'b0; req = 2'b11;
        sample();
        chk("rsthold_mreq", 160'(mreq), 160'(0));
        chk("rsthold_busy", 160'(busy), 160'(0));
        chk("rsthold_ptr0", 160'(gnt), 160'(2'b01));
        tick();
        req = 2'b00; mgnt = 1'b1;
        repeat (2) cyc();

        // wrap-around on the 4-source instance
        req4 = 4'b0100; mgnt4 = 1'b0;
        sample(); chk("wrap_g2", 160'(gnt4), 160'(4'b0100)); tick();
        req4 = 4'b0000; mgnt4 = 1'b1;
        sample(); chk("wrap_sel2", 160'(sel4), 160'(2)); tick();
        req4 = 4'b0101;
        sample(); chk("wrap_g0", 160'(gnt4), 160'(4'b0001)); tick();
        sample();
        chk("wrap_sel0", 160'(sel4), 160'(0));
        chk("wrap_mreq0", 160'(mreq4), 160'(1));
        chk("wrap_len0", 160'(o4_len), 160'(0));
        tick();
        sample(); chk("wrap_g2b", 160'(gnt4), 160'(4'b0100)); tick();
        req4 = 4'b0000;
        sample();
        chk("wrap_sel2b", 160'(sel4), 160'(2));
        chk("wrap_len2", 160'(o4_len), 160'(2));
        tick();
        cyc();

        // randomized traffic against the model
        pend = 2'b00; req = 2'b00;
        repeat (3000) begin
            cyc();
            if (m_win >= 0) pend[m_win] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    src[i]  = rnd_cmd();
                end
            end
            req  = pend;
            mgnt = ($urandom_range(0, 2) != 0);
            rst  = ($urandom_range(0, 79) == 0);
        end
        rst = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
